// File: rtl/board_reset_seq_pkg.sv
// Shared types and constants for the DE10-Pro board reset / bring-up sequencer.
package board_reset_pkg;

  localparam int unsigned CNT_W_DEFAULT = 26;

  typedef enum logic [2:0] {
    NPOR_HOLD = 3'd0,
    SYS_HOLD  = 3'd1,
    CAL_WAIT  = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int LED_SYS_UP    = 0;
  localparam int LED_NPOR      = 1;
  localparam int LED_DDR_READY = 2;
  localparam int LED_ERROR     = 3;

endpackage

// File: rtl/board_reset_seq_if.sv
// Board-side signals of the reset sequencer: raw asynchronous inputs and registered status outputs.
interface board_reset_seq_if;

  logic       cpu_reset_n;
  logic       pcie_perst_n;
  logic       ddr4_b_cal_success;
  logic       ddr4_b_cal_fail;
  logic       ddr4_c_cal_success;
  logic       ddr4_c_cal_fail;
  logic       sys_reset;
  logic       pcie_npor;
  logic       ddr_ready;
  logic       cal_fail;
  logic       cal_timeout;
  logic [3:0] led;
  logic [2:0] state;

  modport master (
    output cpu_reset_n, pcie_perst_n,
    output ddr4_b_cal_success, ddr4_b_cal_fail, ddr4_c_cal_success, ddr4_c_cal_fail,
    input  sys_reset, pcie_npor, ddr_ready, cal_fail, cal_timeout, led, state
  );

  modport slave (
    input  cpu_reset_n, pcie_perst_n,
    input  ddr4_b_cal_success, ddr4_b_cal_fail, ddr4_c_cal_success, ddr4_c_cal_fail,
    output sys_reset, pcie_npor, ddr_ready, cal_fail, cal_timeout, led, state
  );

endinterface

// File: rtl/board_reset_seq_sync_2ff.sv
// Two-flop synchroniser with a selectable value loaded during synchronous reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/board_reset_seq.sv
// Board reset sequencer: holds PCIe npor and the system reset, then waits for both DDR4
// EMIF calibrations and reports ready / fail / timeout. A debounced button restarts it.
module board_reset_seq
  import board_reset_pkg::*;
#(
  parameter int unsigned NPOR_DELAY  = 5000000,
  parameter int unsigned SYS_DELAY   = 1024,
  parameter int unsigned CAL_TIMEOUT = 50000000,
  parameter int unsigned DEBOUNCE    = 500000,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  board_reset_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] NPOR_LAST = CNT_W'(NPOR_DELAY - 1);
  localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_DELAY - 1);
  localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DEB_DONE  = CNT_W'(DEBOUNCE);

  logic btn_n_s, perst_n_s, b_ok_s, b_fail_s, c_ok_s, c_fail_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_btn    (.clk(clk_clk), .rst(reset_reset), .d(bus.cpu_reset_n),        .q(btn_n_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_perst  (.clk(clk_clk), .rst(reset_reset), .d(bus.pcie_perst_n),       .q(perst_n_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_b_ok   (.clk(clk_clk), .rst(reset_reset), .d(bus.ddr4_b_cal_success), .q(b_ok_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_b_fail (.clk(clk_clk), .rst(reset_reset), .d(bus.ddr4_b_cal_fail),    .q(b_fail_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_c_ok   (.clk(clk_clk), .rst(reset_reset), .d(bus.ddr4_c_cal_success), .q(c_ok_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_c_fail (.clk(clk_clk), .rst(reset_reset), .d(bus.ddr4_c_cal_fail),    .q(c_fail_s));

  // Debounce counter saturates one past the press point so a held button fires only once.
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    press     = 1'b0;
    if (btn_n_s) begin
      deb_cnt_d = '0;
    end else begin
      press = (deb_cnt_q == DEB_LAST);
      if (deb_cnt_q != DEB_DONE) deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) deb_cnt_q <= '0;
    else             deb_cnt_q <= deb_cnt_d;
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sys_reset_q, sys_reset_d;
  logic             npor_q, npor_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             tmo_q, tmo_d;
  logic [3:0]       led_q, led_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sys_reset_d = sys_reset_q;
    npor_d      = npor_q;
    ready_d     = ready_q;
    fail_d      = fail_q;
    tmo_d       = tmo_q;
    led_d       = '0;

    case (state_q)
      NPOR_HOLD: begin
        if (!perst_n_s) begin
          cnt_d = '0;
        end else if (cnt_q == NPOR_LAST) begin
          npor_d  = 1'b1;
          cnt_d   = '0;
          state_d = SYS_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SYS_HOLD: begin
        if (cnt_q == SYS_LAST) begin
          sys_reset_d = 1'b0;
          cnt_d       = '0;
          state_d     = CAL_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAL_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (b_fail_s || c_fail_s) begin
          fail_d  = 1'b1;
          state_d = FAIL;
        end else if (b_ok_s && c_ok_s) begin
          ready_d = 1'b1;
          state_d = RUN;
        end else if (cnt_q == CAL_LAST) begin
          tmo_d   = 1'b1;
          state_d = FAIL;
        end
      end
      RUN, FAIL: ;
      default: state_d = NPOR_HOLD;
    endcase

    // In NPOR_HOLD these values already hold, so a press there only restarts the count.
    if (press) begin
      state_d     = NPOR_HOLD;
      cnt_d       = '0;
      sys_reset_d = 1'b1;
      npor_d      = 1'b0;
      ready_d     = 1'b0;
      fail_d      = 1'b0;
      tmo_d       = 1'b0;
    end

    led_d[LED_SYS_UP]    = ~sys_reset_d;
    led_d[LED_NPOR]      = npor_d;
    led_d[LED_DDR_READY] = ready_d;
    led_d[LED_ERROR]     = fail_d | tmo_d;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= NPOR_HOLD;
      cnt_q       <= '0;
      sys_reset_q <= 1'b1;
      npor_q      <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_reset_q <= sys_reset_d;
      npor_q      <= npor_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
      led_q       <= led_d;
    end
  end

  assign bus.sys_reset   = sys_reset_q;
  assign bus.pcie_npor   = npor_q;
  assign bus.ddr_ready   = ready_q;
  assign bus.cal_fail    = fail_q;
  assign bus.cal_timeout = tmo_q;
  assign bus.led         = led_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_board_reset_seq.sv
// Testbench for board_reset_seq: expected outputs come from event-time arithmetic
// (when npor, sys_reset and the calibration verdict should change), not from an FSM copy.
module tb_board_reset_seq;

  localparam int NPOR_D = 8;
  localparam int SYS_D  = 4;
  localparam int CAL_T  = 32;
  localparam int DEB    = 3;

  localparam int K_OK   = 0;
  localparam int K_FAIL = 1;
  localparam int K_NONE = 2;

  typedef struct packed {
    logic       sys_reset;
    logic       npor;
    logic       ready;
    logic       fail;
    logic       tmo;
    logic [3:0] led;
    logic [2:0] state;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  board_reset_seq_if bus ();

  board_reset_seq #(
    .NPOR_DELAY (NPOR_D),
    .SYS_DELAY  (SYS_D),
    .CAL_TIMEOUT(CAL_T),
    .DEBOUNCE   (DEB)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.sys_reset = bus.sys_reset;
    o.npor      = bus.pcie_npor;
    o.ready     = bus.ddr_ready;
    o.fail      = bus.cal_fail;
    o.tmo       = bus.cal_timeout;
    o.led       = bus.led;
    o.state     = bus.state;
    return o;
  endfunction

  // Outputs after edge k, given the edge at which npor should rise, the edge after which
  // the deciding calibration input was driven, and the expected verdict.
  function automatic obs_t model(input int k, input int npor_edge, input int cal_set, input int kind);
    obs_t o;
    int sys_edge;
    int act;
    sys_edge = npor_edge + SYS_D;
    if (kind == K_NONE) act = sys_edge + CAL_T;
    else act = (cal_set + 3 > sys_edge + 1) ? cal_set + 3 : sys_edge + 1;
    o.sys_reset = (k < sys_edge);
    o.npor      = (k >= npor_edge);
    o.ready     = (kind == K_OK) && (k >= act);
    o.fail      = (kind == K_FAIL) && (k >= act);
    o.tmo       = (kind == K_NONE) && (k >= act);
    o.led       = {o.fail | o.tmo, o.ready, o.npor, ~o.sys_reset};
    if (k < npor_edge)     o.state = 3'd0;
    else if (k < sys_edge) o.state = 3'd1;
    else if (k < act)      o.state = 3'd2;
    else if (kind == K_OK) o.state = 3'd3;
    else                   o.state = 3'd4;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic perst);
    rst = 1'b1;
    bus.cpu_reset_n        = 1'b1;
    bus.pcie_perst_n       = perst;
    bus.ddr4_b_cal_success = 1'b0;
    bus.ddr4_b_cal_fail    = 1'b0;
    bus.ddr4_c_cal_success = 1'b0;
    bus.ddr4_c_cal_fail    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    exp = '0;
    exp.sys_reset = 1'b1;
    rst = 1'b1;
    bus.cpu_reset_n        = 1'($urandom_range(0, 1));
    bus.pcie_perst_n       = 1'b1;
    bus.ddr4_b_cal_success = 1'b1;
    bus.ddr4_b_cal_fail    = 1'($urandom_range(0, 1));
    bus.ddr4_c_cal_success = 1'b1;
    bus.ddr4_c_cal_fail    = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      got = observe();
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL reset_state i=%0d got=%b want=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_nominal(input int cal_delay, input int stagger);
    obs_t got, exp;
    int npor_e, c;
    do_reset(1'b1);
    npor_e = NPOR_D + 2;
    c = npor_e + SYS_D + cal_delay;
    for (int k = 1; k <= c + stagger + 12; k++) begin
      tick();
      if (k == c) bus.ddr4_b_cal_success = 1'b1;
      if (k == c + stagger) bus.ddr4_c_cal_success = 1'b1;
      if (k == npor_e + 1) bus.pcie_perst_n = 1'b0;
      if (k == c + stagger + 6) bus.ddr4_b_cal_success = 1'b0;
      @(negedge clk);
      got = observe();
      exp = model(k, npor_e, c + stagger, K_OK);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL nominal edge=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_perst_late(input int p);
    obs_t got, exp;
    do_reset(1'b0);
    for (int k = 1; k <= p + NPOR_D + SYS_D + 8; k++) begin
      tick();
      if (k == p - 8) bus.pcie_perst_n = 1'b1;
      if (k == p - 5) bus.pcie_perst_n = 1'b0;
      if (k == p) bus.pcie_perst_n = 1'b1;
      @(negedge clk);
      got = observe();
      exp = model(k, p + NPOR_D + 2, 0, K_NONE);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL perst_late edge=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_cal_fail(input int d, input int variant);
    obs_t got, exp;
    int c;
    do_reset(1'b1);
    c = NPOR_D + 2 + SYS_D + d;
    for (int k = 1; k <= c + 12; k++) begin
      tick();
      if (k == c) begin
        if (variant == 0) begin
          bus.ddr4_b_cal_fail    = 1'b1;
          bus.ddr4_c_cal_success = 1'b1;
        end else begin
          bus.ddr4_c_cal_fail = 1'b1;
        end
      end
      if (k == c + 5) begin
        bus.ddr4_b_cal_success = 1'b1;
        bus.ddr4_c_cal_success = 1'b1;
      end
      if (k == c + 7) begin
        bus.ddr4_b_cal_fail = 1'b0;
        bus.ddr4_c_cal_fail = 1'b0;
      end
      @(negedge clk);
      got = observe();
      exp = model(k, NPOR_D + 2, c, K_FAIL);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL cal_fail v=%0d edge=%0d got=%b want=%b", variant, k, got, exp);
      end
    end
  endtask

  task automatic test_timeout(input int lone_ok);
    obs_t got, exp;
    int sys_e;
    do_reset(1'b1);
    sys_e = NPOR_D + 2 + SYS_D;
    for (int k = 1; k <= sys_e + CAL_T + 6; k++) begin
      tick();
      if (k == sys_e + lone_ok) bus.ddr4_c_cal_success = 1'b1;
      @(negedge clk);
      got = observe();
      exp = model(k, NPOR_D + 2, 0, K_NONE);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL timeout edge=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_debounce(input int kind, input int hold);
    obs_t got, exp;
    int np_a, c_a, g, b, r;
    do_reset(1'b1);
    np_a = NPOR_D + 2;
    c_a  = np_a + SYS_D + 2;
    g    = c_a + 6;
    b    = g + 10;
    r    = b + 2 + DEB;
    for (int k = 1; k <= r + NPOR_D + SYS_D + 10; k++) begin
      tick();
      if (k == c_a) begin
        if (kind == K_OK) begin
          bus.ddr4_b_cal_success = 1'b1;
          bus.ddr4_c_cal_success = 1'b1;
        end else begin
          bus.ddr4_b_cal_fail = 1'b1;
        end
      end
      if (k == g) bus.cpu_reset_n = 1'b0;
      if (k == g + 2) bus.cpu_reset_n = 1'b1;
      if (k == b) bus.cpu_reset_n = 1'b0;
      if (k == b + hold) bus.cpu_reset_n = 1'b1;
      @(negedge clk);
      got = observe();
      if (k < r) exp = model(k, np_a, c_a, kind);
      else       exp = model(k, r + NPOR_D, c_a, kind);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL debounce kind=%0d hold=%0d edge=%0d got=%b want=%b", kind, hold, k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid(input int off);
    obs_t got, exp;
    int k0, np_b;
    do_reset(1'b1);
    k0   = NPOR_D + 2 + SYS_D + off;
    np_b = k0 + 1 + NPOR_D + 2;
    for (int k = 1; k <= np_b + SYS_D + 8; k++) begin
      tick();
      if (k == k0) begin
        rst = 1'b1;
        bus.ddr4_b_cal_success = 1'b1;
        bus.ddr4_c_cal_success = 1'b1;
      end
      if (k == k0 + 1) rst = 1'b0;
      @(negedge clk);
      got = observe();
      if (k <= k0) exp = model(k, NPOR_D + 2, 0, K_NONE);
      else         exp = model(k, np_b, k0, K_OK);
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL reset_mid edge=%0d got=%b want=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal(5, 0);
    test_nominal($urandom_range(0, 20), $urandom_range(0, 4));
    test_perst_late(20);
    test_perst_late($urandom_range(10, 40));
    test_cal_fail($urandom_range(0, 25), 0);
    test_cal_fail($urandom_range(0, 25), 1);
    test_timeout($urandom_range(0, 40));
    test_debounce(K_OK, $urandom_range(3, 14));
    test_debounce(K_FAIL, $urandom_range(3, 14));
    test_reset_mid($urandom_range(2, 20));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
